idma_stream_sched: RTL and testbench

- Multi-stream scheduler between per-stream iDMA front-ends and a single in-order back-end (or mid-end).
- Round-robin arbitrates N stream request channels onto one dma_req_t channel.
- Assigns per-stream transfer IDs and caps total outstanding transfers.
- Matches in-order back-end completions to streams; drives next_id/done_id/busy per stream.

---
 rtl/idma_stream_sched_pkg.sv | 9 +
 rtl/idma_stream_sched_fifo.sv | 44 ++++
 rtl/idma_stream_sched.sv | 103 ++++++++++
 tb/tb_idma_stream_sched.sv | 131 +++++++++++++
 4 files changed

// File: rtl/idma_stream_sched_pkg.sv
// idma_stream_sched_pkg: width helpers shared by the stream scheduler files
package idma_stream_sched_pkg;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/idma_stream_sched_fifo.sv
// idma_stream_sched_fifo: outstanding-transfer FIFO of stream indices, completed in issue order
module idma_stream_sched_fifo import idma_stream_sched_pkg::*; #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CntW'(Depth);
  assign data_o  = mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d  = push_i ? ((wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1)) : wr_q;
    rd_d  = pop_i ? ((rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1)) : rd_q;
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/idma_stream_sched.sv
// idma_stream_sched: round-robin multi-stream scheduler onto one in-order iDMA back-end
// with per-stream transfer IDs and a global outstanding-transfer cap.
module idma_stream_sched import idma_stream_sched_pkg::*; #(
  parameter int unsigned NumStreams     = 4,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned StreamWidth    = idx_width(NumStreams),
  parameter type         dma_req_t      = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  dma_req_t                  stream_req_i [NumStreams],
  input  logic [NumStreams-1:0]     stream_valid_i,
  output logic [NumStreams-1:0]     stream_ready_o,
  output logic [IdCounterWidth-1:0] next_id_o [NumStreams],
  output logic [IdCounterWidth-1:0] done_id_o [NumStreams],
  output logic [NumStreams-1:0]     busy_o,
  output dma_req_t                  dma_req_o,
  output logic                      dma_valid_o,
  input  logic                      dma_ready_i,
  output logic [StreamWidth-1:0]    stream_idx_o,
  input  logic                      cpl_valid_i,
  output logic                      cpl_ready_o
);
  localparam int unsigned OutW = cnt_width(MaxOutstanding);
  logic [StreamWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, search_idx, win, head;
  logic lock_q, lock_d, fifo_full, fifo_empty, hs, pop;
  logic [IdCounterWidth-1:0] next_id_q [NumStreams];
  logic [IdCounterWidth-1:0] next_id_d [NumStreams];
  logic [IdCounterWidth-1:0] done_id_q [NumStreams];
  logic [IdCounterWidth-1:0] done_id_d [NumStreams];
  logic [OutW-1:0] out_q [NumStreams];
  logic [OutW-1:0] out_d [NumStreams];
  // Descending scan so the lowest offset from the pointer is written last and wins.
  always_comb begin
    logic [StreamWidth-1:0] j;
    j = '0;
    search_idx = rr_q;
    for (int k = int'(NumStreams) - 1; k >= 0; k--) begin
      j = StreamWidth'((int'(rr_q) + k) % NumStreams);
      if (stream_valid_i[j]) search_idx = j;
    end
  end
  // A stalled grant is held until the back-end accepts it.
  assign win          = lock_q ? lock_idx_q : search_idx;
  assign dma_valid_o  = |stream_valid_i && !fifo_full;
  assign dma_req_o    = dma_valid_o ? stream_req_i[win] : '0;
  assign stream_idx_o = win;
  assign cpl_ready_o  = !fifo_empty;
  assign hs           = dma_valid_o && dma_ready_i;
  assign pop          = cpl_valid_i && cpl_ready_o;
  assign next_id_o    = next_id_q;
  assign done_id_o    = done_id_q;
  always_comb begin
    rr_d       = hs ? ((win == StreamWidth'(NumStreams - 1)) ? '0 : win + StreamWidth'(1)) : rr_q;
    lock_d     = dma_valid_o && !dma_ready_i;
    lock_idx_d = win;
    for (int s = 0; s < int'(NumStreams); s++) begin
      stream_ready_o[s] = dma_ready_i && !fifo_full && (win == StreamWidth'(s));
      busy_o[s]         = out_q[s] != '0;
      next_id_d[s]      = next_id_q[s] + IdCounterWidth'(hs && win == StreamWidth'(s));
      done_id_d[s]      = done_id_q[s] + IdCounterWidth'(pop && head == StreamWidth'(s));
      out_d[s]          = out_q[s] + OutW'(hs && win == StreamWidth'(s)) - OutW'(pop && head == StreamWidth'(s));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      next_id_q  <= '{default: IdCounterWidth'(1)};
      done_id_q  <= '{default: '0};
      out_q      <= '{default: '0};
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      next_id_q  <= next_id_d;
      done_id_q  <= done_id_d;
      out_q      <= out_d;
    end
  end
  idma_stream_sched_fifo #(
    .Width(StreamWidth),
    .Depth(MaxOutstanding)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .data_i (win),
    .pop_i  (pop),
    .data_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    dma_valid_o && !dma_ready_i |=> $stable(dma_req_o) && $stable(stream_idx_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(hs && fifo_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(cpl_valid_i && fifo_empty));
  for (genvar g = 0; g < int'(NumStreams); g++) begin : g_out_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni) out_q[g] <= OutW'(MaxOutstanding));
  end
endmodule

// File: tb/tb_idma_stream_sched.sv
// tb_idma_stream_sched: directed checks of arbitration, lock-in, ID tracking, cap and wrap
module tb_idma_stream_sched;
  typedef logic [7:0] req_t;
  logic clk = 1'b0;
  logic rst_n;
  req_t sreq [4];
  logic [3:0] sval, srdy, busy;
  logic [3:0] nid [4];
  logic [3:0] did [4];
  req_t dreq;
  logic dval, drdy, cval, crdy;
  logic [1:0] sidx;
  int tests = 0;
  int fails = 0;

  idma_stream_sched #(
    .NumStreams(4), .IdCounterWidth(4), .MaxOutstanding(8), .dma_req_t(req_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .stream_req_i(sreq), .stream_valid_i(sval),
    .stream_ready_o(srdy), .next_id_o(nid), .done_id_o(did), .busy_o(busy),
    .dma_req_o(dreq), .dma_valid_o(dval), .dma_ready_i(drdy), .stream_idx_o(sidx),
    .cpl_valid_i(cval), .cpl_ready_o(crdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask

  initial begin
    sval = '0; drdy = 1'b0; cval = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) sreq[i] = '0;
    cyc(); cyc();
    chk("rst_nid0", nid[0], 1); chk("rst_nid3", nid[3], 1); chk("rst_did2", did[2], 0);
    chk("rst_busy", busy, 0); chk("rst_dval", dval, 0); chk("rst_crdy", crdy, 0);
    chk("rst_srdy", srdy, 0); chk("rst_sidx", sidx, 0); chk("rst_dreq", dreq, 0);
    rst_n = 1'b1; cyc();
    // single request from stream 2 and its completion
    sreq[2] = 8'hA2; sval = 4'b0100; drdy = 1'b1; settle();
    chk("t1_srdy", srdy, 4'b0100); chk("t1_sidx", sidx, 2); chk("t1_dreq", dreq, 8'hA2);
    cyc(); sval = '0; settle();
    chk("t1_nid2", nid[2], 2); chk("t1_nid1", nid[1], 1); chk("t1_busy", busy, 4'b0100); chk("t1_crdy", crdy, 1);
    cval = 1'b1; cyc(); cval = 1'b0; settle();
    chk("t1_busy_done", busy, 0); chk("t1_did2", did[2], 1); chk("t1_did0", did[0], 0); chk("t1_crdy_done", crdy, 0);
    // mid-run asynchronous reset clears IDs
    rst_n = 1'b0; settle();
    chk("mid_rst_nid2", nid[2], 1);
    rst_n = 1'b1; cyc();
    // all streams valid: round robin until the cap is hit
    sval = 4'b1111; drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_grant", sidx, i % 4);
      cyc();
    end
    settle();
    chk("t2_full_dval", dval, 0); chk("t2_full_srdy", srdy, 0); chk("t2_full_busy", busy, 4'b1111);
    chk("t2_nid0", nid[0], 3); chk("t2_nid3", nid[3], 3);
    cval = 1'b1; settle();
    chk("t2_full_same_cycle", dval, 0);
    cyc(); cval = 1'b0; settle();
    chk("t2_resume_dval", dval, 1); chk("t2_resume_sidx", sidx, 0); chk("t2_resume_srdy", srdy, 4'b0001);
    chk("t2_did0", did[0], 1);
    cyc(); sval = '0; cval = 1'b1;
    repeat (8) cyc();
    cval = 1'b0; settle();
    chk("t2_drain_busy", busy, 0); chk("t2_drain_did0", did[0], 3); chk("t2_drain_did3", did[3], 2);
    chk("t2_drain_nid0", nid[0], 4); chk("t2_drain_crdy", crdy, 0);
    // lock-in: pointer moved to 3 so stream 0 would otherwise win over stream 1
    sreq[2] = 8'h22; sval = 4'b0100; cyc();
    sreq[1] = 8'h11; sval = 4'b0010; drdy = 1'b0; settle();
    chk("t3_sidx", sidx, 1); chk("t3_dval", dval, 1); chk("t3_srdy", srdy, 0);
    cyc(); sreq[0] = 8'h10; sval = 4'b0011; settle();
    chk("t3_lock_sidx", sidx, 1); chk("t3_lock_dreq", dreq, 8'h11);
    cyc(); settle();
    chk("t3_lock_sidx2", sidx, 1); chk("t3_lock_dreq2", dreq, 8'h11);
    drdy = 1'b1; settle();
    chk("t3_grant1_srdy", srdy, 4'b0010); chk("t3_grant1_sidx", sidx, 1);
    cyc(); sval = 4'b0001; settle();
    chk("t3_grant0_sidx", sidx, 0); chk("t3_grant0_srdy", srdy, 4'b0001); chk("t3_grant0_dreq", dreq, 8'h10);
    cyc(); sval = '0; drdy = 1'b0; cval = 1'b1;
    repeat (3) cyc();
    cval = 1'b0; settle();
    chk("t3_busy", busy, 0);
    // completions return to streams in issue order 3,0,3
    rst_n = 1'b0; settle(); rst_n = 1'b1; cyc();
    drdy = 1'b1; sval = 4'b1000; cyc(); sval = 4'b0001; cyc(); sval = 4'b1000; cyc();
    sval = '0; drdy = 1'b0; settle();
    chk("t4_nid3", nid[3], 3); chk("t4_nid0", nid[0], 2);
    cval = 1'b1; cyc(); settle();
    chk("t4_c1_did3", did[3], 1); chk("t4_c1_did0", did[0], 0);
    cyc(); settle();
    chk("t4_c2_did0", did[0], 1); chk("t4_c2_did3", did[3], 1);
    cyc(); cval = 1'b0; settle();
    chk("t4_c3_did3", did[3], 2); chk("t4_busy", busy, 0);
    // same-cycle issue and completion on stream 0
    sval = 4'b0001; drdy = 1'b1; cyc();
    cval = 1'b1; settle();
    chk("t5_crdy", crdy, 1);
    cyc(); sval = '0; cval = 1'b0; drdy = 1'b0; settle();
    chk("t5_nid0", nid[0], 4); chk("t5_did0", did[0], 2); chk("t5_busy", busy, 4'b0001);
    cval = 1'b1; cyc(); cval = 1'b0; settle();
    chk("t5_busy_done", busy, 0); chk("t5_did0_done", did[0], 3);
    // 4-bit IDs wrap 15 -> 0 -> 1
    rst_n = 1'b0; settle(); rst_n = 1'b1; cyc();
    sval = 4'b0001; drdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cval = (i != 0);
      cyc();
      if (i >= 13) chk("t6_wrap_nid0", nid[0], (i + 2) % 16);
    end
    sval = '0; drdy = 1'b0; cval = 1'b0; settle();
    chk("t6_did0", did[0], 15); chk("t6_busy", busy, 4'b0001);
    cval = 1'b1; cyc(); cval = 1'b0; settle();
    chk("t6_did0_wrap", did[0], 0); chk("t6_busy_done", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
